// File: rtl/aes_result_drain.sv
// Buffers 128-bit AES engine results in a FIFO and streams each one to the host
// as four MSB-first 32-bit words over valid/ready; results arriving while full are dropped.
module aes_result_drain #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid,
    input  logic [127:0]               res_data,
    input  logic                       res_en_de,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [31:0]                m_data,
    output logic [1:0]                 m_idx,
    output logic                       m_last,
    output logic                       m_en_de,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [128:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    state_t           state_q, state_d;
    logic [128:0]     hold_q;
    logic [1:0]       idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             push, drop, pop;

    // Fullness is judged on the registered level only, so a same-cycle pop never rescues a push.
    assign push = res_valid && (level_q != LW'(DEPTH));
    assign drop = res_valid && (level_q == LW'(DEPTH));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (level_q != '0) begin
                        pop   = 1'b1;
                        idx_d = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = clr_ovf ? CNT_W'(1) : ((drop_q == '1) ? drop_q : drop_q + CNT_W'(1));
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_en_de, res_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    logic [31:0] word;
    always_comb begin
        word = '0;
        unique case (idx_q)
            2'd0: word = hold_q[127:96];
            2'd1: word = hold_q[95:64];
            2'd2: word = hold_q[63:32];
            2'd3: word = hold_q[31:0];
            default: word = '0;
        endcase
    end

    assign m_valid  = (state_q == SEND);
    assign m_data   = m_valid ? word : 32'd0;
    assign m_idx    = idx_q;
    assign m_last   = m_valid && (idx_q == 2'd3);
    assign m_en_de  = m_valid && hold_q[128];
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;

endmodule
